// File: rtl/vga_axil_regfile_if.sv
// AXI4-Lite bus bundle for the VGA control-path register bank.
// The master modport is the CPU side; the slave modport is the register bank.
interface vga_axil_regfile_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_W = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_W-1:0]     wstrb;
   logic                  wvalid;
   logic                  wready;

   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;

   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/vga_axil_regfile.sv
// AXI4-Lite slave register bank for the VGA control path.
// AW and W are each captured in a one-entry buffer so they may arrive in any
// order; a write commits when both are held and the B slot is free. Reads are
// answered from a registered R slot, one per cycle while rready is high.
module vga_axil_regfile #(
   parameter int                             ADDR_WIDTH = 32,
   parameter int                             DATA_WIDTH = 32,
   parameter int                             NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
   parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           clk,
   input  logic                           arst_n,
   vga_axil_regfile_if.slave              s_axil,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_i,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);
   localparam int STRB_W   = DATA_WIDTH / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   // Full word index width, so out-of-range addresses are never aliased
   localparam int NIDX_W   = ADDR_WIDTH - ADDR_LSB;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                  aw_full_q, aw_full_d;
   logic [NIDX_W-1:0]     aw_idx_q, aw_idx_d;
   logic                  w_full_q, w_full_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

   logic                  aw_hs, w_hs, ar_hs, wr_fire;
   logic                  wr_legal, rd_legal;
   logic [NIDX_W-1:0]     ar_idx;
   logic [NUM_REGS-1:0]   wr_sel, rd_sel;
   logic [DATA_WIDTH-1:0] wr_mask;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [DATA_WIDTH-1:0] slot_val [NUM_REGS];
   logic                  unused_addr;

   // Sub-word address bits carry no information for word registers
   assign unused_addr = ^{s_axil.awaddr[ADDR_LSB-1:0], s_axil.araddr[ADDR_LSB-1:0]};

   assign wr_fire = aw_full_q && w_full_q && (!bvalid_q || s_axil.bready);
   assign s_axil.awready = !aw_full_q || wr_fire;
   assign s_axil.wready  = !w_full_q || wr_fire;
   assign s_axil.arready = !rvalid_q || s_axil.rready;
   assign aw_hs = s_axil.awvalid && s_axil.awready;
   assign w_hs  = s_axil.wvalid && s_axil.wready;
   assign ar_hs = s_axil.arvalid && s_axil.arready;
   assign ar_idx = s_axil.araddr[ADDR_WIDTH-1:ADDR_LSB];

   assign s_axil.bvalid = bvalid_q;
   assign s_axil.bresp  = bresp_q;
   assign s_axil.rvalid = rvalid_q;
   assign s_axil.rresp  = rresp_q;
   assign s_axil.rdata  = rdata_q;
   assign wr_pulse_o    = wr_pulse_q;

   // Only read-write slots can be hit legally; read-only and out-of-range fail
   assign wr_legal = |(wr_sel & ~RO_MASK);
   assign rd_legal = |rd_sel;

   genvar gi;
   for (gi = 0; gi < STRB_W; gi++) begin : g_mask
      assign wr_mask[gi*8 +: 8] = {8{wstrb_q[gi]}};
   end

   for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wr_sel[gi] = (aw_idx_q == NIDX_W'(gi));
      assign rd_sel[gi] = (ar_idx == NIDX_W'(gi));
      if (RO_MASK[gi]) begin : g_ro
         assign slot_val[gi] = reg_i[gi*DATA_WIDTH +: DATA_WIDTH];
         assign reg_o[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else begin : g_rw
         logic [DATA_WIDTH-1:0] val_q, val_d;
         logic                  unused_ri;
         assign unused_ri = ^reg_i[gi*DATA_WIDTH +: DATA_WIDTH];

         // Strobed byte merge when a committed write targets this register
         always_comb begin
            val_d = val_q;
            if (wr_fire && wr_sel[gi]) begin
               val_d = (val_q & ~wr_mask) | (wdata_q & wr_mask);
            end
         end

         // Register storage, restored to its reset image on reset
         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               val_q <= RESET_VAL[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               val_q <= val_d;
            end
         end

         assign slot_val[gi] = val_q;
         assign reg_o[gi*DATA_WIDTH +: DATA_WIDTH] = val_q;
      end
   end

   // Read data mux; the index is one-hot or empty so the last hit wins safely
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_sel[i]) begin
            rd_val = slot_val[i];
         end
      end
   end

   // Buffer fill/drain, write commit and B/R response next-state
   always_comb begin
      aw_full_d  = aw_full_q;
      aw_idx_d   = aw_idx_q;
      w_full_d   = w_full_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      wr_pulse_d = '0;

      if (wr_fire) begin
         aw_full_d  = 1'b0;
         w_full_d   = 1'b0;
         bvalid_d   = 1'b1;
         bresp_d    = wr_legal ? RESP_OKAY : RESP_SLVERR;
         wr_pulse_d = wr_sel & ~RO_MASK;
      end else if (bvalid_q && s_axil.bready) begin
         bvalid_d = 1'b0;
      end

      // A buffer drained by wr_fire may refill in the same cycle
      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_idx_d  = s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
         w_full_d = 1'b1;
         wdata_d  = s_axil.wdata;
         wstrb_d  = s_axil.wstrb;
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_legal ? rd_val : '0;
         rresp_d  = rd_legal ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil.rready) begin
         rvalid_d = 1'b0;
      end
   end

   // Control and response state; reset discards anything in flight
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         aw_full_q  <= 1'b0;
         aw_idx_q   <= '0;
         w_full_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
      end else begin
         aw_full_q  <= aw_full_d;
         aw_idx_q   <= aw_idx_d;
         w_full_q   <= w_full_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end
endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed bench for vga_axil_regfile: 16 x 32-bit registers, register 5
// read-only, registers 0 and 15 with non-zero reset values.
module tb_vga_axil_regfile;
   localparam int NR = 16;
   localparam logic [NR-1:0]    RO   = 16'h0020;
   localparam logic [NR*32-1:0] RV   = {32'hF00D0000, {14{32'h0}}, 32'h0000CAFE};
   localparam logic [31:0]      RI5  = 32'h5A5A0505;
   localparam logic [1:0]       OKAY = 2'b00;
   localparam logic [1:0]       SLVE = 2'b10;

   logic              clk = 1'b0;
   logic              arst_n = 1'b0;
   logic [NR*32-1:0]  reg_o;
   logic [NR*32-1:0]  reg_i;
   logic [NR-1:0]     wr_pulse_o;

   int checks = 0;
   int failures = 0;
   logic [31:0] model [NR];

   vga_axil_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   vga_axil_regfile #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RV)
   ) dut (
      .clk(clk), .arst_n(arst_n), .s_axil(bus),
      .reg_o(reg_o), .reg_i(reg_i), .wr_pulse_o(wr_pulse_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      logic [15:0] exp_pulse;
   } vec_t;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] slot(input int i);
      return reg_o[i*32 +: 32];
   endfunction

   function automatic logic [NR*32-1:0] image();
      logic [NR*32-1:0] v;
      for (int i = 0; i < NR; i++) v[i*32 +: 32] = RO[i] ? 32'h0 : model[i];
      return v;
   endfunction

   function automatic logic [31:0] exp_rd(input int i);
      return RO[i] ? RI5 : model[i];
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : o[b*8 +: 8];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) model[i] = RV[i*32 +: 32];
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_bvalid"}, bus.bvalid, 1'b0);
      check({tag, "_rvalid"}, bus.rvalid, 1'b0);
      check({tag, "_bresp"}, bus.bresp, 2'b00);
      check({tag, "_rresp"}, bus.rresp, 2'b00);
      check({tag, "_rdata"}, bus.rdata, 32'h0);
      check({tag, "_reg_o"}, reg_o, image());
      check({tag, "_pulse"}, wr_pulse_o, 16'h0);
      check({tag, "_readies"}, {bus.awready, bus.wready, bus.arready}, 3'b111);
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [15:0] pulse, output bit ok);
      int n;
      bit aw_t, w_t;
      ok = 1'b0; resp = 2'b11; pulse = '0;
      @(negedge clk);
      bus.awaddr = a; bus.awvalid = 1'b1;
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1; bus.bready = 1'b1;
      n = 0;
      while ((bus.awvalid || bus.wvalid) && n < 20) begin
         #1;
         aw_t = bus.awvalid && bus.awready;
         w_t  = bus.wvalid && bus.wready;
         @(negedge clk);
         if (aw_t) bus.awvalid = 1'b0;
         if (w_t) bus.wvalid = 1'b0;
         n++;
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      n = 0;
      while (!bus.bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.bvalid) begin
         ok = 1'b1; resp = bus.bresp; pulse = wr_pulse_o;
      end
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output bit ok);
      int n;
      bit t;
      ok = 1'b0; d = 'x; resp = 2'b11;
      @(negedge clk);
      bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
      n = 0;
      while (bus.arvalid && n < 20) begin
         #1;
         t = bus.arvalid && bus.arready;
         @(negedge clk);
         if (t) bus.arvalid = 1'b0;
         n++;
      end
      bus.arvalid = 1'b0;
      n = 0;
      while (!bus.rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (bus.rvalid) begin
         ok = 1'b1; d = bus.rdata; resp = bus.rresp;
      end
   endtask

   // Hard stop in case something hangs outside the bounded loops
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [16];
      logic [1:0]  resp;
      logic [15:0] pulse;
      logic [31:0] rd;
      bit          ok;
      logic [31:0] bp_data [3];
      int          j, b;
      bit          take;

      vecs[0]  = '{1'b1, 32'h0000000C, 32'hAABBCCDD, 4'hF, 32'h0,        OKAY, 16'h0008};
      vecs[1]  = '{1'b1, 32'h0000000C, 32'h11223344, 4'h5, 32'h0,        OKAY, 16'h0008};
      vecs[2]  = '{1'b0, 32'h0000000C, 32'h0,        4'h0, 32'hAA22CC44, OKAY, 16'h0};
      vecs[3]  = '{1'b1, 32'h00000040, 32'h12345678, 4'hF, 32'h0,        SLVE, 16'h0000};
      vecs[4]  = '{1'b0, 32'h00000040, 32'h0,        4'h0, 32'h00000000, SLVE, 16'h0};
      vecs[5]  = '{1'b1, 32'h00000014, 32'hFFFFFFFF, 4'hF, 32'h0,        SLVE, 16'h0000};
      vecs[6]  = '{1'b0, 32'h00000014, 32'h0,        4'h0, RI5,          OKAY, 16'h0};
      vecs[7]  = '{1'b0, 32'h00000000, 32'h0,        4'h0, 32'h0000CAFE, OKAY, 16'h0};
      vecs[8]  = '{1'b0, 32'h0000003C, 32'h0,        4'h0, 32'hF00D0000, OKAY, 16'h0};
      vecs[9]  = '{1'b1, 32'h00000018, 32'h01020304, 4'h0, 32'h0,        OKAY, 16'h0040};
      vecs[10] = '{1'b0, 32'h00000018, 32'h0,        4'h0, 32'h00000000, OKAY, 16'h0};
      vecs[11] = '{1'b0, 32'h00000009, 32'h0,        4'h0, 32'hDEADBEEF, OKAY, 16'h0};
      vecs[12] = '{1'b1, 32'h0000001F, 32'hFFFFFFFF, 4'h8, 32'h0,        OKAY, 16'h0080};
      vecs[13] = '{1'b0, 32'h0000001C, 32'h0,        4'h0, 32'hFF000000, OKAY, 16'h0};
      vecs[14] = '{1'b0, 32'hFFFFFFF0, 32'h0,        4'h0, 32'h00000000, SLVE, 16'h0};
      vecs[15] = '{1'b0, 32'h00000004, 32'h0,        4'h0, 32'h12345678, OKAY, 16'h0};

      for (int i = 0; i < NR; i++) reg_i[i*32 +: 32] = (i == 5) ? RI5 : (32'hBAD00000 | i);
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_state("rst_hold");
      arst_n = 1'b1;
      @(negedge clk);
      check_reset_state("rst_rel");

      // Write 0xDEADBEEF to 0x8: B and update one edge after the handshake edge
      @(negedge clk);
      bus.awaddr = 32'h8; bus.awvalid = 1'b1;
      bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      #1 check("wr8_ready", {bus.awready, bus.wready}, 2'b11);
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("wr8_b_early", bus.bvalid, 1'b0);
      check("wr8_pulse_early", wr_pulse_o, 16'h0);
      @(negedge clk);
      check("wr8_bvalid", bus.bvalid, 1'b1);
      check("wr8_bresp", bus.bresp, OKAY);
      check("wr8_reg2", slot(2), 32'hDEADBEEF);
      check("wr8_pulse", wr_pulse_o, 16'h0004);
      @(negedge clk);
      check("wr8_b_done", bus.bvalid, 1'b0);
      check("wr8_pulse_once", wr_pulse_o, 16'h0);
      model[2] = 32'hDEADBEEF;
      axi_read(32'h8, rd, resp, ok);
      check("rd8_done", ok, 1'b1);
      check("rd8_data", rd, 32'hDEADBEEF);
      check("rd8_resp", resp, OKAY);
      $display("txn WR addr=00000008 data=deadbeef then RD data=%08h resp=%0d", rd, resp);

      // W arrives 3 cycles ahead of AW
      @(negedge clk);
      bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      #1 check("wfirst_wready", bus.wready, 1'b1);
      @(negedge clk);
      bus.wvalid = 1'b0;
      repeat (2) @(negedge clk);
      check("wfirst_no_b", bus.bvalid, 1'b0);
      bus.awaddr = 32'h4; bus.awvalid = 1'b1;
      #1 check("wfirst_awready", bus.awready, 1'b1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      check("wfirst_b_early", bus.bvalid, 1'b0);
      @(negedge clk);
      check("wfirst_bvalid", bus.bvalid, 1'b1);
      check("wfirst_bresp", bus.bresp, OKAY);
      check("wfirst_reg1", slot(1), 32'h12345678);
      check("wfirst_pulse", wr_pulse_o, 16'h0002);
      model[1] = 32'h12345678;
      $display("txn WR (W before AW) addr=00000004 data=12345678 resp=%0d", bus.bresp);

      // Table: strobes, illegal accesses, read-only source, address alignment
      for (int k = 0; k < 16; k++) begin
         if (vecs[k].wr) begin
            axi_write(vecs[k].addr, vecs[k].data, vecs[k].strb, resp, pulse, ok);
            check($sformatf("v%0d_wr_done", k), ok, 1'b1);
            check($sformatf("v%0d_bresp", k), resp, vecs[k].exp_resp);
            check($sformatf("v%0d_pulse", k), pulse, vecs[k].exp_pulse);
            if (vecs[k].exp_resp == OKAY)
               model[vecs[k].addr[5:2]] = merge(model[vecs[k].addr[5:2]], vecs[k].data, vecs[k].strb);
            $display("txn %0d WR addr=%08h data=%08h strb=%h resp=%0d pulse=%04h",
                     k, vecs[k].addr, vecs[k].data, vecs[k].strb, resp, pulse);
         end else begin
            axi_read(vecs[k].addr, rd, resp, ok);
            check($sformatf("v%0d_rd_done", k), ok, 1'b1);
            check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_data);
            check($sformatf("v%0d_rresp", k), resp, vecs[k].exp_resp);
            $display("txn %0d RD addr=%08h data=%08h resp=%0d", k, vecs[k].addr, rd, resp);
         end
      end
      check("table_reg_o", reg_o, image());

      // Back-to-back: 8 writes to regs 8..15 and 8 reads of regs 0..7 in parallel
      bus.bready = 1'b1; bus.rready = 1'b1;
      for (int n = 0; n < 11; n++) begin
         @(negedge clk);
         if (n >= 1 && n <= 8) begin
            check($sformatf("tp_rvalid%0d", n), bus.rvalid, 1'b1);
            check($sformatf("tp_rdata%0d", n), bus.rdata, exp_rd(n - 1));
            check($sformatf("tp_rresp%0d", n), bus.rresp, OKAY);
            $display("txn TP RD idx=%0d data=%08h", n - 1, bus.rdata);
         end else begin
            check($sformatf("tp_rvalid%0d", n), bus.rvalid, 1'b0);
         end
         if (n >= 2 && n <= 9) begin
            check($sformatf("tp_bvalid%0d", n), bus.bvalid, 1'b1);
            check($sformatf("tp_bresp%0d", n), bus.bresp, OKAY);
            check($sformatf("tp_reg%0d", n + 6), slot(n + 6), 32'hA5000000 | (n - 2));
            check($sformatf("tp_pulse%0d", n), wr_pulse_o, 16'h1 << (n + 6));
            $display("txn TP WR idx=%0d resp=%0d", n + 6, bus.bresp);
         end else begin
            check($sformatf("tp_bvalid%0d", n), bus.bvalid, 1'b0);
         end
         if (n < 8) begin
            bus.awaddr = 32'h20 + 4 * n; bus.awvalid = 1'b1;
            bus.wdata = 32'hA5000000 | n; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
            bus.araddr = 4 * n; bus.arvalid = 1'b1;
            #1 check($sformatf("tp_ready%0d", n),
                     {bus.awready, bus.wready, bus.arready}, 3'b111);
         end else begin
            bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
         end
      end
      for (int i = 0; i < 8; i++) model[8 + i] = 32'hA5000000 | i;

      // Backpressure: bready low, three writes queued to regs 9..11
      bp_data[0] = 32'hC0DE0009; bp_data[1] = 32'hC0DE000A; bp_data[2] = 32'hC0DE000B;
      @(negedge clk);
      bus.bready = 1'b0;
      j = 0;
      for (int c = 0; c < 5; c++) begin
         if (j < 3) begin
            bus.awaddr = 32'h24 + 4 * j; bus.awvalid = 1'b1;
            bus.wdata = bp_data[j]; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
         end else begin
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
         end
         #1;
         check($sformatf("bp_ready_c%0d", c), {bus.awready, bus.wready}, (c < 2) ? 2'b11 : 2'b00);
         if (c >= 2) begin
            check($sformatf("bp_bvalid_c%0d", c), bus.bvalid, 1'b1);
            check($sformatf("bp_bresp_c%0d", c), bus.bresp, OKAY);
         end
         take = bus.awvalid && bus.awready && bus.wvalid && bus.wready;
         @(negedge clk);
         if (take) j++;
      end
      bus.bready = 1'b1;
      b = 0;
      for (int n = 0; n < 10 && b < 3; n++) begin
         if (j < 3) begin
            bus.awaddr = 32'h24 + 4 * j; bus.awvalid = 1'b1;
            bus.wdata = bp_data[j]; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
         end else begin
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
         end
         #1;
         if (bus.bvalid) begin
            check($sformatf("bp_b%0d_resp", b), bus.bresp, OKAY);
            check($sformatf("bp_b%0d_reg", b), slot(9 + b), bp_data[b]);
            if (b < 2) check($sformatf("bp_b%0d_next_old", b), slot(10 + b), model[10 + b]);
            $display("txn BP WR idx=%0d resp=%0d", 9 + b, bus.bresp);
            b++;
         end
         take = bus.awvalid && bus.awready && bus.wvalid && bus.wready;
         @(negedge clk);
         if (take) j++;
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("bp_b_count", b, 3);
      for (int i = 0; i < 3; i++) model[9 + i] = bp_data[i];
      @(negedge clk);
      check("bp_reg_o", reg_o, image());

      // Reset mid-operation: buffered AW and pending R are discarded
      @(negedge clk);
      bus.awaddr = 32'h8; bus.awvalid = 1'b1;
      bus.araddr = 32'h0; bus.arvalid = 1'b1; bus.rready = 1'b0;
      @(negedge clk);
      bus.awvalid = 1'b0; bus.arvalid = 1'b0;
      check("mid_rvalid_pre", bus.rvalid, 1'b1);
      #2 arst_n = 1'b0;
      #2;
      model_reset();
      check_reset_state("mid_rst");
      @(negedge clk);
      arst_n = 1'b1;
      bus.rready = 1'b1;
      bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      @(negedge clk);
      bus.wvalid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_no_b", bus.bvalid, 1'b0);
      check("mid_no_r", bus.rvalid, 1'b0);
      check("mid_reg2", slot(2), 32'h0);
      check("mid_pulse", wr_pulse_o, 16'h0);
      $display("txn RESET mid-operation bvalid=%0b rvalid=%0b", bus.bvalid, bus.rvalid);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
